// File: rtl/prime_engine.sv
// Self-sequenced primality engine: counts the divisors of a latched operand by
// repeated subtraction and reports the count and a prime flag over start/busy/done.
module prime_engine #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] n,
   output logic             busy,
   output logic             done,
   output logic             is_prime,
   output logic [WIDTH-1:0] div_count,
   output logic [WIDTH-1:0] sal
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] TWO  = {{(WIDTH-2){1'b0}}, 2'b10};

   state_t           state_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] k_r;
   logic [WIDTH-1:0] c_r;
   logic [WIDTH-1:0] n_r;
   logic [WIDTH-1:0] c_eval_s;

   // Divisor count including the current remainder evaluation
   always_comb begin
      c_eval_s = c_r;
      if (a_r == ZERO) begin
         c_eval_s = c_r + ONE;
      end else begin
         c_eval_s = c_r;
      end
   end

   // Control FSM with datapath registers and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         a_r       <= ZERO;
         k_r       <= ZERO;
         c_r       <= ZERO;
         n_r       <= ZERO;
         busy      <= 1'b0;
         done      <= 1'b0;
         is_prime  <= 1'b0;
         div_count <= ZERO;
         sal       <= ZERO;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  n_r <= n;
                  sal <= n;
                  a_r <= n;
                  k_r <= n;
                  c_r <= ZERO;
                  // Zero has no divisors in 1..N, so finish on the start edge
                  if (n == ZERO) begin
                     state_r   <= FIN;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     div_count <= ZERO;
                     is_prime  <= 1'b0;
                  end else begin
                     state_r <= SUB;
                     busy    <= 1'b1;
                  end
               end
            end
            SUB: begin
               if (a_r >= k_r) begin
                  a_r <= a_r - k_r;
               end else begin
                  c_r <= c_eval_s;
                  if (k_r == ONE) begin
                     state_r   <= FIN;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     div_count <= c_eval_s;
                     is_prime  <= (c_eval_s == TWO);
                  end else begin
                     k_r <= k_r - ONE;
                     a_r <= n_r;
                  end
               end
            end
            FIN: begin
               done    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule
